ioctl_dl_pacer: RTL

- Sits directly upstream of the core's ROM-download port, between the ioctl download bus and the core's dn_addr/dn_data/dn_wr inputs.
- Filters download beats by ioctl_index and buffers them in a small FIFO.
- Replays each beat to the core as a one-cycle dn_wr strobe with stable address/data and a guaranteed minimum spacing.
- Raises ioctl_wait to back-pressure the host before the FIFO can overflow.

---
 rtl/ioctl_dl_pacer_if.sv | 32 +++
 rtl/ioctl_dl_pacer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_dl_pacer_if.sv
// rtl/ioctl_dl_pacer_if.sv - ioctl download bus and core download port bundle
interface ioctl_dl_pacer_if #(
  parameter int ADDR_W = 16
);
  // Host-side ioctl download bus
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              ioctl_wait;

  // Core-side download port and status
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;
  logic              dl_active;
  logic              dl_overflow;
  logic              dl_range_err;

  // Host / environment side
  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  ioctl_wait, dn_addr, dn_data, dn_wr, dl_active, dl_overflow, dl_range_err
  );

  // Pacer side
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output ioctl_wait, dn_addr, dn_data, dn_wr, dl_active, dl_overflow, dl_range_err
  );
endinterface

// File: rtl/ioctl_dl_pacer.sv
// rtl/ioctl_dl_pacer.sv - filters, buffers and paces ioctl download beats into the core
module ioctl_dl_pacer #(
  parameter int         DEPTH  = 8,
  parameter int         GAP    = 4,
  parameter int         ADDR_W = 16,
  parameter logic [7:0] INDEX  = 8'h00
) (
  input  logic                clk_12,
  input  logic                reset_n,
  ioctl_dl_pacer_if.slave     bus
);

  localparam int         PTR_W    = $clog2(DEPTH);
  localparam int         CNT_W    = PTR_W + 1;
  localparam int         ENT_W    = ADDR_W + 8;
  localparam bit         HAS_GAP  = (GAP > 0);
  localparam logic [7:0] GAP_LOAD = HAS_GAP ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         gap_cnt_q, gap_cnt_d;

  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [ADDR_W-1:0]  dn_addr_q;
  logic [7:0]         dn_data_q;
  logic               wait_q;
  logic               active_q;
  logic               overflow_q, overflow_d;
  logic               range_err_q, range_err_d;
  logic               download_q;

  logic               accept;
  logic [24:0]        addr_hi;
  logic               addr_bad;
  logic               push_req;
  logic               push_ok;
  logic               drop_full;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic               dl_rise;
  logic [ENT_W-1:0]   wr_entry;
  logic [ENT_W-1:0]   rd_entry;

  // Beat qualification: anything not addressed to us is ignored without a trace
  assign accept     = bus.ioctl_download & bus.ioctl_wr & (bus.ioctl_index == INDEX);
  assign addr_hi    = bus.ioctl_addr >> ADDR_W;
  assign addr_bad   = |addr_hi;
  assign push_req   = accept & ~addr_bad;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));

  // A pop in the same cycle frees the slot, so a full FIFO can still take a beat
  assign push_ok    = push_req & (~fifo_full | pop);
  assign drop_full  = push_req & fifo_full & ~pop;

  assign wr_entry   = {bus.ioctl_addr[ADDR_W-1:0], bus.ioctl_dout};
  assign rd_entry   = mem_q[rd_ptr_q];

  assign dl_rise    = bus.ioctl_download & ~download_q;

  // FIFO pointer and occupancy next-state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  // Sticky error flags: a new download window wipes them, a fresh error re-arms them
  always_comb begin
    overflow_d  = overflow_q;
    range_err_d = range_err_q;
    if (dl_rise) begin
      overflow_d  = 1'b0;
      range_err_d = 1'b0;
    end
    if (drop_full) begin
      overflow_d = 1'b1;
    end
    if (accept && addr_bad) begin
      range_err_d = 1'b1;
    end
  end

  // Output FSM: pop one entry, strobe it for one cycle, then hold off for GAP cycles
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (HAS_GAP) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and gap counter registers
  always_ff @(posedge clk_12) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk_12) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // FIFO pointers and occupancy; reset discards anything queued
  always_ff @(posedge clk_12) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Core address/data hold register, updated only on the IDLE->STROBE pop
  always_ff @(posedge clk_12) begin
    if (!reset_n) begin
      dn_addr_q <= '0;
      dn_data_q <= 8'd0;
    end else if (pop) begin
      dn_addr_q <= rd_entry[ENT_W-1:8];
      dn_data_q <= rd_entry[7:0];
    end
  end

  // Status registers; wait rises with two slots left to absorb the beat already in flight
  always_ff @(posedge clk_12) begin
    if (!reset_n) begin
      wait_q      <= 1'b0;
      active_q    <= 1'b0;
      overflow_q  <= 1'b0;
      range_err_q <= 1'b0;
      download_q  <= 1'b0;
    end else begin
      wait_q      <= (count_d >= CNT_W'(DEPTH - 2));
      active_q    <= bus.ioctl_download | ~fifo_empty | (state_q != ST_IDLE);
      overflow_q  <= overflow_d;
      range_err_q <= range_err_d;
      download_q  <= bus.ioctl_download;
    end
  end

  assign bus.ioctl_wait   = wait_q;
  assign bus.dn_addr      = dn_addr_q;
  assign bus.dn_data      = dn_data_q;
  assign bus.dn_wr        = (state_q == ST_STROBE);
  assign bus.dl_active    = active_q;
  assign bus.dl_overflow  = overflow_q;
  assign bus.dl_range_err = range_err_q;

endmodule
